// File: rtl/mem_arbiter_if.sv
// Shared-memory port bundle: CPU and debug requester handshakes plus the memory strobe side.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/debug arbiter for one single-port memory: gnt+mem_en 1 cycle after the request is sampled, read data 3 cycles after.
// Requesters hold req until gnt; CPU has priority unless debug has lost STARVE_MAX arbitrations in a row.
module mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state;
    state_t        state_nxt;
    logic          owner_dbg;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    wait_cnt;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;
    logic          cpu_rvalid_q;
    logic          dbg_rvalid_q;
    logic          any_req;
    logic          dbg_win;
    logic          arb;

    assign any_req = bus.cpu_req | bus.dbg_req;
    assign dbg_win = bus.dbg_req & (~bus.cpu_req | (wait_cnt == STARVE_LIM));
    assign arb     = (state == IDLE) & any_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = we_q ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The winning request is latched so mem_* never depends combinationally on req inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_dbg <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (arb) begin
            owner_dbg <= dbg_win;
            we_q      <= dbg_win ? bus.dbg_we    : bus.cpu_we;
            addr_q    <= dbg_win ? bus.dbg_addr  : bus.cpu_addr;
            wdata_q   <= dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (arb) begin
            if (dbg_win) begin
                wait_cnt <= '0;
            end else if (bus.dbg_req && (wait_cnt < STARVE_LIM)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if (state == RESP) begin
                if (owner_dbg) begin
                    dbg_rdata_q  <= bus.mem_rdata;
                    dbg_rvalid_q <= 1'b1;
                end else begin
                    cpu_rdata_q  <= bus.mem_rdata;
                    cpu_rvalid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_en     = (state == ACCESS);
    assign bus.mem_we     = (state == ACCESS) & we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_gnt    = (state == ACCESS) & ~owner_dbg;
    assign bus.dbg_gnt    = (state == ACCESS) & owner_dbg;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

endmodule
